fft_r2_iter: RTL

Iterative, in-place radix-2 decimation-in-time FFT engine with a parametrised point count and data width. It is the sequential successor to the fully unrolled butterfly array: one shared complex butterfly is reused across all stages over a single dual-port sample RAM. Samples stream in through a valid/ready port in natural order and are written to bit-reversed addresses. Results stream out through a valid/ready port in natural order. The block sits between the sample source (ADC or ROM loader) and the spectrum consumer.

---
 rtl/fft_r2_iter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/fft_r2_iter.sv
// Iterative in-place radix-2 DIT FFT: one shared butterfly over a dual-port sample RAM.
// Twiddles are generated from cos/sin at elaboration; TW_FILE is kept for compatibility with the ROM-loaded variant.
module fft_r2_iter #(
  parameter int    LOG2N   = 5,
  parameter int    DW      = 32,
  parameter int    TW      = 16,
  parameter int    SCALE   = 1,
  parameter string TW_FILE = "twiddle.txt"
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_re,
  input  logic [DW-1:0]    in_im,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_re,
  output logic [DW-1:0]    out_im,
  output logic [LOG2N-1:0] out_idx,
  output logic             out_last,
  output logic             busy
);
  localparam int N  = 1 << LOG2N;
  localparam int H  = N / 2;
  localparam int PW = DW + TW + 1;

  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;
  state_t state;

  logic [2*DW-1:0]    mem [N];
  logic [2*TW-1:0]    tw_rom [H];
  logic [LOG2N-1:0]   load_cnt, load_rev, cyc, rd_cnt;
  logic [3:0]         stg;
  logic               accept, issue, wv;
  logic [LOG2N-1:0]   jx, half, mask, a_addr, b_addr, wa_q, wb_q;
  logic [LOG2N-2:0]   k_addr;
  logic [2*DW-1:0]    ra, rb, bf_a, bf_b;
  logic [2*TW-1:0]    tw_q;

  for (genvar k = 0; k < H; k++) begin : g_tw
    localparam real ANG = 6.283185307179586 * k / N;
    localparam real CV  = $cos(ANG) * (1 << (TW-2));
    localparam real SV  = -$sin(ANG) * (1 << (TW-2));
    localparam int  CR  = (CV >= 0.0) ? $rtoi(CV + 0.5) : -$rtoi(0.5 - CV);
    localparam int  SR  = (SV >= 0.0) ? $rtoi(SV + 0.5) : -$rtoi(0.5 - SV);
    assign tw_rom[k] = {TW'(CR), TW'(SR)};
  end

  assign accept = in_valid && in_ready;

  // Butterfly j of stage s: a = (j with bit s shifted up) , b = a + 2**s.
  always_comb begin
    load_rev = '0;
    for (int i = 0; i < LOG2N; i++) load_rev[i] = load_cnt[LOG2N-1-i];
    issue  = (state == COMPUTE) && (cyc < LOG2N'(H));
    jx     = {1'b0, cyc[LOG2N-2:0]};
    half   = LOG2N'(1) << stg;
    mask   = half - LOG2N'(1);
    a_addr = ((jx & ~mask) << 1) | (jx & mask);
    b_addr = a_addr | half;
    k_addr = (LOG2N-1)'((jx & mask) << (LOG2N - 1 - stg));
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      ra   <= mem[a_addr];
      rb   <= mem[b_addr];
      tw_q <= tw_rom[k_addr];
      wa_q <= a_addr;
      wb_q <= b_addr;
    end
  end

  logic signed [DW-1:0]    ar, ai, br, bi;
  logic signed [TW-1:0]    wr, wi;
  logic signed [DW+TW-1:0] br_x, bi_x, wr_x, wi_x, m_rr, m_ii, m_ri, m_ir;
  logic signed [PW-1:0]    p_re_f, p_im_f;
  logic signed [DW:0]      p_re, p_im, a_re_x, a_im_x, s_re, s_im, d_re, d_im;

  always_comb begin
    {ar, ai} = ra;
    {br, bi} = rb;
    {wr, wi} = tw_q;
    br_x   = {{TW{br[DW-1]}}, br};
    bi_x   = {{TW{bi[DW-1]}}, bi};
    wr_x   = {{DW{wr[TW-1]}}, wr};
    wi_x   = {{DW{wi[TW-1]}}, wi};
    m_rr   = br_x * wr_x;
    m_ii   = bi_x * wi_x;
    m_ri   = br_x * wi_x;
    m_ir   = bi_x * wr_x;
    p_re_f = {m_rr[DW+TW-1], m_rr} - {m_ii[DW+TW-1], m_ii} + PW'(1 << (TW-3));
    p_im_f = {m_ri[DW+TW-1], m_ri} + {m_ir[DW+TW-1], m_ir} + PW'(1 << (TW-3));
    p_re   = (DW+1)'(p_re_f >>> (TW-2));
    p_im   = (DW+1)'(p_im_f >>> (TW-2));
    a_re_x = {ar[DW-1], ar};
    a_im_x = {ai[DW-1], ai};
    s_re   = a_re_x + p_re;
    s_im   = a_im_x + p_im;
    d_re   = a_re_x - p_re;
    d_im   = a_im_x - p_im;
    bf_a   = (SCALE != 0) ? {s_re[DW:1], s_im[DW:1]} : {s_re[DW-1:0], s_im[DW-1:0]};
    bf_b   = (SCALE != 0) ? {d_re[DW:1], d_im[DW:1]} : {d_re[DW-1:0], d_im[DW-1:0]};
  end

  // Port A is shared by the loader and the butterfly write-back; they never overlap in time.
  always_ff @(posedge clk) begin
    if (wv) begin
      mem[wa_q] <= bf_a;
      mem[wb_q] <= bf_b;
    end else if (accept) begin
      mem[load_rev] <= {in_re, in_im};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= LOAD;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      load_cnt  <= '0;
      stg       <= '0;
      cyc       <= '0;
      rd_cnt    <= '0;
      wv        <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_idx   <= '0;
    end else begin
      wv <= issue;
      case (state)
        LOAD: if (accept) begin
          load_cnt <= load_cnt + 1'b1;
          if (load_cnt == LOG2N'(N-1)) begin
            state    <= COMPUTE;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        COMPUTE: begin
          // Two idle cycles after each stage's last issue let its write-back land before the next read.
          if (cyc == LOG2N'(H+1)) begin
            cyc <= '0;
            if (stg == 4'(LOG2N-1)) begin
              stg    <= '0;
              rd_cnt <= '0;
              state  <= UNLOAD;
            end else begin
              stg <= stg + 1'b1;
            end
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        UNLOAD: begin
          if (!out_valid || (out_ready && !out_last)) begin
            out_valid <= 1'b1;
            out_re    <= mem[rd_cnt][2*DW-1:DW];
            out_im    <= mem[rd_cnt][DW-1:0];
            out_idx   <= rd_cnt;
            out_last  <= (rd_cnt == LOG2N'(N-1));
            rd_cnt    <= rd_cnt + 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule
